lcd_bus_sequencer: RTL
======================

# lcd_bus_sequencer

Owns the 6-pin HD44780-style character LCD bus on the Nexys 4 chess timer and sequences every access to it. After reset it runs the mandatory 4-bit power-on initialisation, then accepts one byte at a time (command or data) over a valid/ready handshake. For each accepted byte it drives the two-nibble transfer with correct enable pulse widths and the post-command busy delay. The display-content logic that formats player times sits upstream and only issues byte writes; it never touches `lcd` timing.

## Interface
Parameters (all in `clk` cycles, 100 MHz):
- `T_PWR`, 2_000_000, power-on wait before the first nibble (20 ms).
- `T_INIT1`, 500_000, wait after the first 0x3 nibble (5 ms).
- `T_INIT2`, 15_000, wait after the second 0x3 nibble (150 µs).
- `T_SU`, 4, RS/data setup before E rises.
- `T_EH`, 50, E high width.
- `T_NIB`, 100, E low hold after each nibble.
- `T_CMD`, 5_000, busy wait after a normal byte (50 µs).
- `T_LONG`, 200_000, busy wait after clear (0x01) or home (0x02) commands with `rs=0` (2 ms).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_valid` in 1: upstream has a byte.
- `wr_rs` in 1: 0 = command, 1 = data.
- `wr_data` in 8: byte to write.
- `wr_ready` out 1: sequencer can accept a byte.
- `init_done` out 1: power-on sequence finished; sticky until `rst`.
- `lcd` out 6: `[5]`=RS, `[4]`=E, `[3:0]`=DB7..DB4. R/W is tied low on the board.

## Operation
- Reset: `lcd`=6'b0, `wr_ready`=0, `init_done`=0, state PWR_WAIT, delay counter loaded with `T_PWR`. `rst` mid-transfer aborts immediately and restarts the full init. No partial nibble is completed.
- States: PWR_WAIT, NIB_SETUP, NIB_EHIGH, NIB_EHOLD, DELAY, IDLE. An init step index and a nibble select (high/low) qualify the current position.
- Init sequence, with RS=0 throughout:
  - single nibbles 0x3 (then `T_INIT1`), 0x3 (then `T_INIT2`), 0x3 (then `T_CMD`), 0x2 (then `T_CMD`);
  - full bytes 0x28 (`T_CMD`), 0x0C (`T_CMD`), 0x01 (`T_LONG`), 0x06 (`T_CMD`);
  - then `init_done`=1 and enter IDLE.
- Nibble transfer: NIB_SETUP drives RS and the nibble with E=0 for `T_SU` cycles. NIB_EHIGH sets E=1 for `T_EH` cycles. NIB_EHOLD returns E=0 for `T_NIB` cycles. RS and data are held constant through all three phases.
- Byte transfer: high nibble first, then low nibble, then DELAY of `T_LONG` if `rs=0` and `data∈{0x01,0x02}`, else `T_CMD`.
- Handshake: `wr_ready`=1 only in IDLE. A transfer is accepted when `wr_valid & wr_ready` is high at a rising edge. `wr_rs`/`wr_data` are latched on that edge, and `wr_ready` is 0 from the next cycle. Inputs are ignored at all other times, including during init.
- In IDLE and DELAY: E=0, RS and data hold their last values.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Handshake at edge k: `lcd` shows RS and the high nibble from cycle k+1.
  - E is high during cycles k+1+`T_SU` … k+`T_SU`+`T_EH`.
  - The low nibble's E pulse starts `T_SU+T_EH+T_NIB` cycles after the high nibble's.
  - `wr_ready` returns high at cycle k+1+2·(`T_SU`+`T_EH`+`T_NIB`)+T_wait.
- With `wr_valid` held high, back-to-back bytes are separated by exactly one IDLE cycle.
- Single delay counter, width `$clog2` of the largest parameter +1. It loads with (value−1) on state entry and advances state at zero. Every parameter must be ≥1.
- `init_done` rises in the same cycle `wr_ready` first rises.

## Structure
- Shared package `lcd_pkg`:
  - state enum;
  - `lcd` bit indices (RS, E, data slice);
  - init nibble/byte constants and their per-step delay selectors;
  - CLEAR/HOME opcodes.
- One sub-module: `lcd_delay_timer` (load, value, `done` pulse), instanced once.
- Init steps come from a small constant table in the package, indexed by step counter. No per-step states.

## Test plan
Use small parameters: `T_PWR`=10, `T_INIT1`=12, `T_INIT2`=6, `T_SU`=2, `T_EH`=3, `T_NIB`=4, `T_CMD`=8, `T_LONG`=20.
- Reset, then idle -> E pulses with DB=3,3,3,2 at the init timing, then bytes 28,0C,01,06 as nibble pairs; `init_done`/`wr_ready` rise together; `lcd`=0 throughout reset.
- After init, write `rs=1`, 0x4B -> `lcd`=6'b100100 with E pulse, then 6'b101011 with E pulse; `wr_ready` back exactly 1+18+8=27 cycles after handshake.
- Write `rs=0`, 0x01 -> DELAY uses 20 cycles; `wr_ready` at +39. `rs=1`, 0x01 uses 8 cycles.
- `wr_valid` held high with four bytes during init -> none consumed until `init_done`; then back-to-back with one IDLE cycle between transfers.
- Assert `rst` during the E high of a low nibble -> next cycle `lcd`=0, `wr_ready`=0, `init_done`=0; the full init replays.
- Change `wr_data` every cycle during a transfer -> output nibbles match the byte latched at the handshake.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus sequencer: states, bus bit
// positions and the power-on init step table.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT, NIB_SETUP, NIB_EHIGH, NIB_EHOLD, DELAY, IDLE
  } state_t;

  localparam int RS_BIT = 5;
  localparam int E_BIT  = 4;
  localparam int DB_HI  = 3;
  localparam int DB_LO  = 0;

  typedef enum logic [1:0] {D_INIT1, D_INIT2, D_CMD, D_LONG} dly_sel_t;

  // full=0 steps send only the high nibble of val (8-bit interface wake-up)
  typedef struct packed {
    logic     full;
    logic [7:0] val;
    dly_sel_t dly;
  } init_step_t;

  localparam logic [2:0] INIT_LAST = 3'd7;
  localparam logic [7:0] OP_CLEAR  = 8'h01;
  localparam logic [7:0] OP_HOME   = 8'h02;

  function automatic init_step_t init_step(input logic [2:0] idx);
    init_step_t s;
    case (idx)
      3'd0:    s = '{full: 1'b0, val: 8'h30, dly: D_INIT1};
      3'd1:    s = '{full: 1'b0, val: 8'h30, dly: D_INIT2};
      3'd2:    s = '{full: 1'b0, val: 8'h30, dly: D_CMD};
      3'd3:    s = '{full: 1'b0, val: 8'h20, dly: D_CMD};
      3'd4:    s = '{full: 1'b1, val: 8'h28, dly: D_CMD};
      3'd5:    s = '{full: 1'b1, val: 8'h0C, dly: D_CMD};
      3'd6:    s = '{full: 1'b1, val: 8'h01, dly: D_LONG};
      default: s = '{full: 1'b1, val: 8'h06, dly: D_CMD};
    endcase
    return s;
  endfunction

  function automatic logic is_long(input logic rs, input logic [7:0] d);
    return !rs && (d == OP_CLEAR || d == OP_HOME);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Down-counter shared by every timed phase; done is high while the count is zero.
module lcd_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;

  // loading value-1 makes a phase last exactly value cycles
  always_ff @(posedge clk) begin
    if (load)              cnt <= value - W'(1);
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780 4-bit bus owner: power-on init, then one upstream byte at a time as
// a high/low nibble pair followed by the command busy delay.
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int T_PWR   = 2_000_000,
  parameter int T_INIT1 = 500_000,
  parameter int T_INIT2 = 15_000,
  parameter int T_SU    = 4,
  parameter int T_EH    = 50,
  parameter int T_NIB   = 100,
  parameter int T_CMD   = 5_000,
  parameter int T_LONG  = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic [5:0] lcd
);
  localparam int CW = $clog2(max2(max2(max2(T_PWR, T_INIT1), max2(T_INIT2, T_SU)),
                                  max2(max2(T_EH, T_NIB), max2(T_CMD, T_LONG)))) + 1;

  state_t        state, state_nx;
  logic [2:0]    step, step_nx;
  logic          lo, lo_nx, rs_q, rs_nx, full_q, full_nx;
  logic [7:0]    dat_q, dat_nx;
  logic          ld, done;
  logic [CW-1:0] ld_val, wait_val;
  init_step_t    st;
  logic [5:0]    lcd_nx;

  lcd_delay_timer #(.W(CW)) u_timer (
    .clk  (clk),
    .load (rst | ld),
    .value(rst ? CW'(T_PWR) : ld_val),
    .done (done)
  );

  // DELAY looks ahead to the step it is about to load; other states use the current one
  assign st = init_step(state == DELAY ? step + 3'd1 : step);

  always_comb begin
    wait_val = CW'(T_CMD);
    if (!init_done) begin
      case (st.dly)
        D_INIT1: wait_val = CW'(T_INIT1);
        D_INIT2: wait_val = CW'(T_INIT2);
        D_LONG:  wait_val = CW'(T_LONG);
        default: wait_val = CW'(T_CMD);
      endcase
    end else if (is_long(rs_q, dat_q)) begin
      wait_val = CW'(T_LONG);
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    lo_nx    = lo;
    rs_nx    = rs_q;
    dat_nx   = dat_q;
    full_nx  = full_q;
    ld       = 1'b0;
    ld_val   = CW'(T_SU);
    case (state)
      PWR_WAIT: if (done) begin
        state_nx = NIB_SETUP; ld = 1'b1;
        rs_nx = 1'b0; dat_nx = st.val; full_nx = st.full; lo_nx = 1'b0;
      end
      NIB_SETUP: if (done) begin
        state_nx = NIB_EHIGH; ld = 1'b1; ld_val = CW'(T_EH);
      end
      NIB_EHIGH: if (done) begin
        state_nx = NIB_EHOLD; ld = 1'b1; ld_val = CW'(T_NIB);
      end
      NIB_EHOLD: if (done) begin
        ld = 1'b1;
        if (full_q && !lo) begin
          state_nx = NIB_SETUP; lo_nx = 1'b1;
        end else begin
          state_nx = DELAY; ld_val = wait_val;
        end
      end
      DELAY: if (done) begin
        if (init_done || step == INIT_LAST) begin
          state_nx = IDLE;
        end else begin
          state_nx = NIB_SETUP; ld = 1'b1; step_nx = step + 3'd1;
          rs_nx = 1'b0; dat_nx = st.val; full_nx = st.full; lo_nx = 1'b0;
        end
      end
      IDLE: if (wr_valid) begin
        state_nx = NIB_SETUP; ld = 1'b1;
        rs_nx = wr_rs; dat_nx = wr_data; full_nx = 1'b1; lo_nx = 1'b0;
      end
      default: state_nx = PWR_WAIT;
    endcase

    lcd_nx                = '0;
    lcd_nx[RS_BIT]        = rs_nx;
    lcd_nx[E_BIT]         = (state_nx == NIB_EHIGH);
    lcd_nx[DB_HI:DB_LO]   = lo_nx ? dat_nx[3:0] : dat_nx[7:4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWR_WAIT;
      step      <= '0;
      lo        <= 1'b0;
      rs_q      <= 1'b0;
      dat_q     <= '0;
      full_q    <= 1'b0;
      lcd       <= '0;
      wr_ready  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      step      <= step_nx;
      lo        <= lo_nx;
      rs_q      <= rs_nx;
      dat_q     <= dat_nx;
      full_q    <= full_nx;
      lcd       <= lcd_nx;
      wr_ready  <= (state_nx == IDLE);
      init_done <= init_done | (state_nx == IDLE);
    end
  end
endmodule
